// File: rtl/core_pkg.sv
// Types and constants shared by the fetch stage and the control unit.
package core_pkg;

  localparam int          INSTR_WIDTH = 32;
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;  // addi x0,x0,0
  localparam logic [31:0] RESET_PC    = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_SKID = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_skid_buffer.sv
// Single-entry {instr, pc} holding register with push/pop/flush and a full flag.
module fetch_skid_buffer
  import core_pkg::INSTR_WIDTH;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [INSTR_WIDTH-1:0] push_instr,
  input  logic [ADDR_WIDTH-1:0]  push_pc,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0]  pc,
  output logic                   full
);

  logic                   full_q;
  logic [INSTR_WIDTH-1:0] instr_q;
  logic [ADDR_WIDTH-1:0]  pc_q;

  always_ff @(posedge clk) begin
    if (rst)        full_q <= 1'b0;
    else if (flush) full_q <= 1'b0;
    else if (push)  full_q <= 1'b1;
    else if (pop)   full_q <= 1'b0;
  end

  // NOTE: payload registers carry no reset; full_q alone says whether they mean anything.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      instr_q <= push_instr;
      pc_q    <= push_pc;
    end
  end

  assign instr = instr_q;
  assign pc    = pc_q;
  assign full  = full_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC register, single-outstanding imem handshake, decode valid/ready output.
module fetch_unit
  import core_pkg::INSTR_WIDTH;
  import core_pkg::fetch_state_t;
  import core_pkg::S_REQ;
  import core_pkg::S_WAIT;
  import core_pkg::S_SKID;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(core_pkg::RESET_PC),
  parameter logic [INSTR_WIDTH-1:0] NOP_INSTR = core_pkg::NOP_INSTR
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pc_src_i,
  input  logic [ADDR_WIDTH-1:0]  target_i,
  output logic                   imem_req_o,
  output logic [ADDR_WIDTH-1:0]  imem_addr_o,
  input  logic                   imem_gnt_i,
  input  logic                   imem_rvalid_i,
  input  logic [INSTR_WIDTH-1:0] imem_rdata_i,
  output logic [INSTR_WIDTH-1:0] instr_o,
  output logic [ADDR_WIDTH-1:0]  pc_o,
  output logic [ADDR_WIDTH-1:0]  pc_plus4_o,
  output logic                   instr_valid_o,
  input  logic                   decode_ready_i
);

  localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] PC_MASK = ~ADDR_WIDTH'(3);

  fetch_state_t           state_q, state_d;
  logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
  logic                   squash_q, squash_d;
  logic                   out_valid_q;
  logic [INSTR_WIDTH-1:0] out_instr_q;
  logic [ADDR_WIDTH-1:0]  out_pc_q;

  logic                   slot_free;
  logic                   out_load, out_clear;
  logic                   skid_push, skid_pop, skid_flush, skid_full;
  logic [INSTR_WIDTH-1:0] skid_instr;
  logic [ADDR_WIDTH-1:0]  skid_pc;

  assign slot_free = !out_valid_q || decode_ready_i;

  fetch_skid_buffer #(.ADDR_WIDTH(ADDR_WIDTH)) u_skid (
    .clk        (clk),
    .rst        (rst),
    .push       (skid_push),
    .pop        (skid_pop),
    .flush      (skid_flush),
    .push_instr (imem_rdata_i),
    .push_pc    (pc_q),
    .instr      (skid_instr),
    .pc         (skid_pc),
    .full       (skid_full)
  );

  // NOTE: every register here is written with <= so all of them update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_REQ;
      pc_q     <= RESET_PC;
      squash_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      squash_q <= squash_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_instr_q <= NOP_INSTR;
      out_pc_q    <= RESET_PC;
    end else if (out_clear) begin
      out_valid_q <= 1'b0;
    end else if (out_load) begin
      out_valid_q <= 1'b1;
      out_instr_q <= imem_rdata_i;
      out_pc_q    <= pc_q;
    end else if (skid_pop) begin
      out_valid_q <= 1'b1;
      out_instr_q <= skid_instr;
      out_pc_q    <= skid_pc;
    end else if (out_valid_q && decode_ready_i) begin
      out_valid_q <= 1'b0;
    end
  end

  // NOTE: defaults first so no path through the case leaves a signal unassigned (no latches).
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    squash_d   = squash_q;
    out_load   = 1'b0;
    out_clear  = 1'b0;
    skid_push  = 1'b0;
    skid_pop   = 1'b0;
    skid_flush = 1'b0;

    if (pc_src_i) begin
      pc_d       = target_i & PC_MASK;
      out_clear  = 1'b1;
      skid_flush = 1'b1;
      if (squash_q) begin
        // A stale response is already being discarded; it completes normally.
        if (imem_rvalid_i) begin
          squash_d = 1'b0;
          state_d  = S_REQ;
        end
      end else if ((state_q == S_WAIT && !imem_rvalid_i) ||
                   (state_q == S_REQ && imem_req_o && imem_gnt_i)) begin
        squash_d = 1'b1;
        state_d  = S_WAIT;
      end else begin
        state_d  = S_REQ;
      end
    end else begin
      unique case (state_q)
        S_REQ: begin
          if (imem_req_o && imem_gnt_i) state_d = S_WAIT;
        end
        S_WAIT: begin
          if (imem_rvalid_i) begin
            if (squash_q) begin
              squash_d = 1'b0;
              state_d  = S_REQ;
            end else if (slot_free) begin
              out_load = 1'b1;
              pc_d     = pc_q + PC_STEP;
              state_d  = S_REQ;
            end else begin
              skid_push = 1'b1;
              pc_d      = pc_q + PC_STEP;
              state_d   = S_SKID;
            end
          end
        end
        S_SKID: begin
          if (slot_free) begin
            skid_pop = 1'b1;
            state_d  = S_REQ;
          end
        end
        default: state_d = S_REQ;
      endcase
    end
  end

  always_comb begin
    imem_req_o    = !rst && (state_q == S_REQ) && (slot_free || !skid_full);
    imem_addr_o   = pc_q;
    instr_valid_o = out_valid_q;
    instr_o       = out_valid_q ? out_instr_q : NOP_INSTR;
    pc_o          = out_pc_q;
    pc_plus4_o    = out_pc_q + PC_STEP;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with a hand-driven instruction memory.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        pc_src_i;
  logic [31:0] target_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;
  logic        instr_valid_o;
  logic        decode_ready_i;

  int n_asserts = 0;
  int n_fail    = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .pc_src_i       (pc_src_i),
    .target_i       (target_i),
    .imem_req_o     (imem_req_o),
    .imem_addr_o    (imem_addr_o),
    .imem_gnt_i     (imem_gnt_i),
    .imem_rvalid_i  (imem_rvalid_i),
    .imem_rdata_i   (imem_rdata_i),
    .instr_o        (instr_o),
    .pc_o           (pc_o),
    .pc_plus4_o     (pc_plus4_o),
    .instr_valid_o  (instr_valid_o),
    .decode_ready_i (decode_ready_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Request at exp_addr, grant it, return data the following cycle.
  task automatic issue(input string tag, input logic [31:0] exp_addr, input logic [31:0] data);
    check({tag, "_req"}, {31'd0, imem_req_o}, 32'd1);
    check({tag, "_addr"}, imem_addr_o, exp_addr);
    imem_gnt_i = 1'b1;
    tick();
    imem_gnt_i = 1'b0;
    check({tag, "_wait_noreq"}, {31'd0, imem_req_o}, 32'd0);
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = data;
    tick();
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = 32'hxxxx_xxxx;
  endtask

  task automatic check_out(input string tag, input logic [31:0] instr, input logic [31:0] pc);
    check({tag, "_valid"}, {31'd0, instr_valid_o}, 32'd1);
    check({tag, "_instr"}, instr_o, instr);
    check({tag, "_pc"}, pc_o, pc);
    check({tag, "_pc4"}, pc_plus4_o, pc + 32'd4);
  endtask

  initial begin
    rst = 1'b1; pc_src_i = 1'b0; target_i = '0;
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0;
    decode_ready_i = 1'b1;
    tick();
    tick();

    // Reset state
    check("rst_req", {31'd0, imem_req_o}, 32'd0);
    check("rst_valid", {31'd0, instr_valid_o}, 32'd0);
    check("rst_instr", instr_o, NOP);
    check("rst_pc", pc_o, 32'h0);
    check("rst_pc4", pc_plus4_o, 32'h4);
    rst = 1'b0;
    #1;

    // Streaming with ready held high
    issue("s0", 32'h0, 32'h00A0_0093);
    check_out("o0", 32'h00A0_0093, 32'h0);
    issue("s1", 32'h4, 32'h00B0_0113);
    check_out("o1", 32'h00B0_0113, 32'h4);
    issue("s2", 32'h8, 32'h00C0_0193);
    check_out("o2", 32'h00C0_0193, 32'h8);

    // Decode stalls: next response parks in the skid, no further request
    decode_ready_i = 1'b0;
    issue("s3", 32'hC, 32'h00D0_0213);
    for (int i = 0; i < 3; i++) begin
      check("stall_noreq", {31'd0, imem_req_o}, 32'd0);
      check("stall_instr", instr_o, 32'h00C0_0193);
      check("stall_pc", pc_o, 32'h8);
      tick();
    end
    decode_ready_i = 1'b1;
    tick();
    check_out("skid_out", 32'h00D0_0213, 32'hC);
    check("resume_req", {31'd0, imem_req_o}, 32'd1);
    check("resume_addr", imem_addr_o, 32'h10);

    // Redirect while waiting: stale response dropped
    decode_ready_i = 1'b0;
    imem_gnt_i = 1'b1;
    tick();
    imem_gnt_i = 1'b0;
    check("pre_redir_valid", {31'd0, instr_valid_o}, 32'd1);
    pc_src_i = 1'b1; target_i = 32'h100;
    tick();
    pc_src_i = 1'b0;
    check("redir_valid", {31'd0, instr_valid_o}, 32'd0);
    check("redir_instr", instr_o, NOP);
    tick();
    check("squash_noreq", {31'd0, imem_req_o}, 32'd0);
    tick();
    imem_rvalid_i = 1'b1; imem_rdata_i = 32'hDEAD_DEAD;
    tick();
    imem_rvalid_i = 1'b0;
    check("squash_valid", {31'd0, instr_valid_o}, 32'd0);
    decode_ready_i = 1'b1;
    check("squash_req", {31'd0, imem_req_o}, 32'd1);
    check("squash_addr", imem_addr_o, 32'h100);

    // Redirect coinciding with rvalid, unaligned target
    imem_gnt_i = 1'b1;
    tick();
    imem_gnt_i = 1'b0;
    imem_rvalid_i = 1'b1; imem_rdata_i = 32'hBEEF_BEEF;
    pc_src_i = 1'b1; target_i = 32'h203;
    tick();
    imem_rvalid_i = 1'b0; pc_src_i = 1'b0;
    check("same_valid", {31'd0, instr_valid_o}, 32'd0);
    issue("s4", 32'h200, 32'h0010_0293);
    check_out("o4", 32'h0010_0293, 32'h200);

    // Reset with a valid output and a full skid
    decode_ready_i = 1'b0;
    issue("s5", 32'h204, 32'h0020_0313);
    check("skidfull_instr", instr_o, 32'h0010_0293);
    rst = 1'b1;
    tick();
    check("mid_rst_valid", {31'd0, instr_valid_o}, 32'd0);
    check("mid_rst_instr", instr_o, NOP);
    check("mid_rst_pc", pc_o, 32'h0);
    check("mid_rst_req", {31'd0, imem_req_o}, 32'd0);
    rst = 1'b0;
    decode_ready_i = 1'b1;
    #1;
    check("post_rst_req", {31'd0, imem_req_o}, 32'd1);
    check("post_rst_addr", imem_addr_o, 32'h0);

    // PC wrap at the top of the address space
    pc_src_i = 1'b1; target_i = 32'hFFFF_FFFF;
    tick();
    pc_src_i = 1'b0;
    issue("s6", 32'hFFFF_FFFC, 32'h0030_0393);
    check("wrap_pc", pc_o, 32'hFFFF_FFFC);
    check("wrap_pc4", pc_plus4_o, 32'h0);
    check("wrap_addr", imem_addr_o, 32'h0);

    // Back-to-back redirects: last target wins
    pc_src_i = 1'b1; target_i = 32'h300;
    tick();
    target_i = 32'h400;
    tick();
    pc_src_i = 1'b0;
    check("b2b_valid", {31'd0, instr_valid_o}, 32'd0);
    check("b2b_addr", imem_addr_o, 32'h400);

    // Redirect in the same cycle as a grant squashes that fetch
    imem_gnt_i = 1'b1; pc_src_i = 1'b1; target_i = 32'h500;
    tick();
    imem_gnt_i = 1'b0; pc_src_i = 1'b0;
    check("gnt_redir_noreq", {31'd0, imem_req_o}, 32'd0);
    imem_rvalid_i = 1'b1; imem_rdata_i = 32'hBAD0_BAD0;
    tick();
    imem_rvalid_i = 1'b0;
    check("gnt_redir_valid", {31'd0, instr_valid_o}, 32'd0);
    check("gnt_redir_addr", imem_addr_o, 32'h500);
    check("gnt_redir_req", {31'd0, imem_req_o}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage that produces the 32-bit instruction word consumed by the control unit and the datapath decode logic.
- Owns the PC register and runs a single-outstanding-request handshake to instruction memory.
- Presents instr/pc/pc+4 to decode with a valid/ready handshake.
- Applies branch/jump redirects (pc_src) and flushes any stale in-flight fetch.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- ADDR_WIDTH, 32, PC and memory address width.
- NOP_INSTR, 32'h0000_0013, instr_o value whenever instr_valid_o=0 (addi x0,x0,0).

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- pc_src_i  in  1  redirect request from execute (branch taken / jump).
- target_i  in  ADDR_WIDTH  redirect target; bits [1:0] ignored.
- imem_req_o  out  1  request valid to instruction memory.
- imem_addr_o  out  ADDR_WIDTH  word-aligned fetch address.
- imem_gnt_i  in  1  memory accepts request this cycle.
- imem_rvalid_i  in  1  read data valid; at most one per granted request, earliest the cycle after grant.
- imem_rdata_i  in  32  instruction word.
- instr_o  out  32  instruction to decode.
- pc_o  out  ADDR_WIDTH  address of instr_o.
- pc_plus4_o  out  ADDR_WIDTH  pc_o + 4, for JAL/JALR link.
- instr_valid_o  out  1  instr_o/pc_o valid.
- decode_ready_i  in  1  decode consumes the output this cycle when valid.

Behaviour:
- Reset (rst=1 at edge):
  - pc_q=RESET_PC, state=S_REQ, squash=0, skid empty.
  - instr_valid_o=0, instr_o=NOP_INSTR, pc_o=RESET_PC, pc_plus4_o=RESET_PC+4.
  - imem_req_o=0 while rst is high.
  - Applies mid-transaction: an outstanding response is not squashed by flag; memory must be reset with the core.
- pc_q[1:0] is always 2'b00. pc+4 wraps modulo 2^ADDR_WIDTH with no error.
- Output slot is "free" when instr_valid_o=0, or when instr_valid_o=1 and decode_ready_i=1.
- States:
  - S_REQ:
    - imem_req_o = slot free or skid empty (never when skid is full); imem_addr_o=pc_q.
    - On req & gnt -> S_WAIT.
  - S_WAIT:
    - imem_req_o=0.
    - On rvalid with squash=1: drop data, clear squash -> S_REQ.
    - On rvalid with squash=0 and slot free: load output (instr, pc_q), pc_q+=4 -> S_REQ.
    - On rvalid with squash=0 and slot not free: load skid, pc_q+=4 -> S_SKID.
  - S_SKID:
    - imem_req_o=0.
    - When slot free: move skid to output -> S_REQ.
- Throughput: one instruction per 2 cycles with a zero-wait memory (request, then response). Latency from grant to instr_valid_o is rvalid cycle + 1.
- Redirect (pc_src_i=1) has priority over every other event in the same cycle:
  - pc_q<=target_i & ~3; instr_valid_o<=0; skid cleared; state<=S_REQ.
  - If in S_WAIT without rvalid this cycle, or in S_REQ with gnt this cycle: squash<=1, state<=S_WAIT (the old-PC response is discarded).
  - If rvalid arrives the same cycle as the redirect: the data is dropped and squash stays 0.
  - A redirect while squash is already 1 only updates pc_q.
- decode_ready_i is ignored while instr_valid_o=0. Output holds stable while valid & !ready.
- Back-to-back redirects on consecutive cycles: the last target wins.

Decomposition:
- Shared package (core_pkg): fetch_state_t enum {S_REQ, S_WAIT, S_SKID}; NOP_INSTR and RESET_PC constants; INSTR_WIDTH=32. The control unit also uses these.
- One sub-module is natural: fetch_skid_buffer. It is a single-entry {instr, pc} register with push/pop/flush and a full flag, reused by later pipeline stages.
- PC register and the FSM stay in fetch_unit.

Test Plan:
- Reset release, memory gnt=1 and rvalid the following cycle, decode_ready=1 → addresses 0x0, 0x4, 0x8 issued; instr_o shows each rdata with pc_o matching; pc_plus4_o=pc_o+4.
- decode_ready=0 held for 5 cycles after the first instruction → output stable; second response lands in skid, no third request; ready=1 → skid to output next cycle, then request resumes at 0x8.
- pc_src_i=1 with target 0x100 while in S_WAIT, rvalid 3 cycles later → that rdata never appears; next request address is 0x100; instr_valid_o is 0 from the redirect edge.
- Redirect in the same cycle as rvalid, target 0x203 → data dropped; next address is 0x200; no extra rvalid is waited for.
- rst asserted while instr_valid_o=1 and skid full → next cycle instr_valid_o=0, instr_o=0x00000013; first request after rst falls is RESET_PC.
- PC at 0xFFFF_FFFC fetch completes → next request address is 0x0000_0000.
